// File: rtl/nco_lockin_pkg.sv
// Shared widths and type helpers for the NCO lock-in demodulator.
package nco_lockin_pkg;

  localparam int unsigned NCO_W_DEF        = 13;
  localparam int unsigned ADC_W_DEF        = 14;
  localparam int unsigned ACC_LEN_LOG2_DEF = 10;

  // Accumulator width that cannot overflow for 2**acc_len_log2 full-scale products.
  function automatic int unsigned out_width(input int unsigned nco_w,
                                            input int unsigned adc_w,
                                            input int unsigned acc_len_log2);
    return nco_w + adc_w + acc_len_log2;
  endfunction

  typedef logic signed [NCO_W_DEF+ADC_W_DEF-1:0] prod_t;
  typedef logic signed [NCO_W_DEF+ADC_W_DEF+ACC_LEN_LOG2_DEF-1:0] acc_t;

endpackage

// File: rtl/lockin_mac.sv
// Two-stage multiply-accumulate: registered product, then integration over 2**ACC_LEN_LOG2
// products with a one-cycle dump pulse carrying the finished sum.
module lockin_mac
  import nco_lockin_pkg::*;
#(
  parameter int unsigned NCO_W        = NCO_W_DEF,
  parameter int unsigned ADC_W        = ADC_W_DEF,
  parameter int unsigned ACC_LEN_LOG2 = ACC_LEN_LOG2_DEF,
  parameter int unsigned OUT_W        = out_width(NCO_W, ADC_W, ACC_LEN_LOG2)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clken,
  input  logic                    i_enable,
  input  logic                    i_nco_valid,
  input  logic signed [NCO_W-1:0] i_nco_sin,
  input  logic signed [ADC_W-1:0] i_adc_data,
  output logic                    o_dump,
  output logic signed [OUT_W-1:0] o_sum
);

  localparam int unsigned PROD_W = NCO_W + ADC_W;

  logic signed [PROD_W-1:0]       r_prod;
  logic                           r_p_vld;
  logic signed [OUT_W-1:0]        r_acc;
  logic        [ACC_LEN_LOG2-1:0] r_cnt;

  logic signed [PROD_W-1:0] w_sin_ext;
  logic signed [PROD_W-1:0] w_adc_ext;
  logic signed [PROD_W-1:0] w_mul;
  logic signed [OUT_W-1:0]  w_prod_ext;
  logic signed [OUT_W-1:0]  w_sum;
  logic                     w_step;
  logic                     w_last;

  // Operands widened first so the product is computed at full signed width.
  assign w_sin_ext  = {{ADC_W{i_nco_sin[NCO_W-1]}}, i_nco_sin};
  assign w_adc_ext  = {{NCO_W{i_adc_data[ADC_W-1]}}, i_adc_data};
  assign w_mul      = w_sin_ext * w_adc_ext;
  assign w_prod_ext = {{(OUT_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_step     = i_enable & i_clken & r_p_vld;
  assign w_last     = (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prod  <= '0;
      r_p_vld <= 1'b0;
    end else if (!i_enable) begin
      r_p_vld <= 1'b0;
    end else if (i_clken) begin
      r_p_vld <= i_nco_valid;
      if (i_nco_valid) begin
        r_prod <= w_mul;
      end
    end
  end

  // The closing product restarts the accumulator at zero so the next integral has no gap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (!i_enable) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + ACC_LEN_LOG2'(1);
      r_acc <= w_last ? '0 : w_sum;
    end
  end

  assign o_dump = w_step & w_last;
  assign o_sum  = w_sum;

endmodule

// File: rtl/nco_lockin_accum.sv
// Lock-in accumulator top: MAC core plus a result holding register with valid/ready
// handshake and a sticky overrun flag for integrals dropped while the output is full.
module nco_lockin_accum
  import nco_lockin_pkg::*;
#(
  parameter int unsigned NCO_W        = NCO_W_DEF,
  parameter int unsigned ADC_W        = ADC_W_DEF,
  parameter int unsigned ACC_LEN_LOG2 = ACC_LEN_LOG2_DEF,
  parameter int unsigned OUT_W        = out_width(NCO_W, ADC_W, ACC_LEN_LOG2)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    enable,
  input  logic                    nco_valid,
  input  logic signed [NCO_W-1:0] nco_sin,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun,
  input  logic                    clr_ovr
);

  logic                    w_dump;
  logic signed [OUT_W-1:0] w_sum;
  logic                    w_load;
  logic                    w_drop;

  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_overrun;

  lockin_mac #(
    .NCO_W        (NCO_W),
    .ADC_W        (ADC_W),
    .ACC_LEN_LOG2 (ACC_LEN_LOG2),
    .OUT_W        (OUT_W)
  ) u_mac (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clken     (clken),
    .i_enable    (enable),
    .i_nco_valid (nco_valid),
    .i_nco_sin   (nco_sin),
    .i_adc_data  (adc_data),
    .o_dump      (w_dump),
    .o_sum       (w_sum)
  );

  // A dump lands if the holding register is empty or being drained this same edge.
  assign w_load = w_dump & (~r_out_valid | out_ready);
  assign w_drop = w_dump & r_out_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_data  <= w_sum;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_nco_lockin_accum.sv
// Scoreboard bench for nco_lockin_accum with 4-product integrals.
module tb_nco_lockin_accum;

  localparam int unsigned NCO_W        = 13;
  localparam int unsigned ADC_W        = 14;
  localparam int unsigned ACC_LEN_LOG2 = 2;
  localparam int unsigned OUT_W        = NCO_W + ADC_W + ACC_LEN_LOG2;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    clken;
  logic                    enable;
  logic                    nco_valid;
  logic signed [NCO_W-1:0] nco_sin;
  logic signed [ADC_W-1:0] adc_data;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    overrun;
  logic                    clr_ovr;

  logic signed [OUT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errs   = 0;

  nco_lockin_accum #(
    .NCO_W        (NCO_W),
    .ADC_W        (ADC_W),
    .ACC_LEN_LOG2 (ACC_LEN_LOG2),
    .OUT_W        (OUT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clken     (clken),
    .enable    (enable),
    .nco_valid (nco_valid),
    .nco_sin   (nco_sin),
    .adc_data  (adc_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: every accepted result is popped and compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_result: got %0d, expected no result", out_data);
        end else begin
          check("result", longint'(out_data), longint'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int a);
    nco_valid = 1'b1;
    nco_sin   = NCO_W'(s);
    adc_data  = ADC_W'(a);
    tick();
    nco_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; clken = 1'b1; enable = 1'b1; nco_valid = 1'b0;
    nco_sin = '0; adc_data = '0; out_ready = 1'b1; clr_ovr = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    tick();

    // 1: basic integral and two-edge latency
    exp_q.push_back(20000);
    for (int i = 0; i < 4; i++) send(50, 100);
    check("lat_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    drain();

    // 2: full-scale signed products
    exp_q.push_back(134217728);
    for (int i = 0; i < 4; i++) send(-4096, -8192);
    exp_q.push_back(-134184960);
    for (int i = 0; i < 4; i++) send(4095, -8192);
    drain();

    // 3: gaps in nco_valid
    exp_q.push_back(4);
    for (int i = 0; i < 8; i++) begin
      nco_valid = (i % 2 == 0);
      nco_sin = 1; adc_data = 1;
      tick();
    end
    nco_valid = 1'b0;
    drain();

    // 4: full output, drop, overrun set/clear, set beats clear
    out_ready = 1'b0;
    exp_q.push_back(12);
    for (int i = 0; i < 8; i++) send(1, 3);
    tick();
    check("ovr_set", overrun, 1);
    check("held_data", out_data, 12);
    check("held_valid", out_valid, 1);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("ovr_clr", overrun, 0);
    for (int i = 0; i < 4; i++) send(1, 3);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    check("held_data2", out_data, 12);
    clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
    check("ovr_clr2", overrun, 0);
    out_ready = 1'b1;
    tick();
    check("valid_drop", out_valid, 0);
    drain();

    // 5: accept and dump on the same edge
    out_ready = 1'b0;
    exp_q.push_back(16);
    for (int i = 0; i < 4; i++) send(2, 2);
    exp_q.push_back(12);
    for (int i = 0; i < 4; i++) send(3, 1);
    out_ready = 1'b1;
    tick();
    check("same_edge_valid", out_valid, 1);
    check("same_edge_data", out_data, 12);
    check("same_edge_ovr", overrun, 0);
    tick();
    check("same_edge_done", out_valid, 0);
    drain();

    // 6: reset, enable drop and clken stall mid-integral
    send(7, 7); send(7, 7);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    exp_q.push_back(40);
    for (int i = 0; i < 4; i++) send(2, 5);
    drain();

    send(7, 7); send(7, 7);
    enable = 1'b0; tick(); enable = 1'b1;
    exp_q.push_back(40);
    for (int i = 0; i < 4; i++) send(2, 5);
    drain();

    exp_q.push_back(40);
    send(2, 5); send(2, 5);
    clken = 1'b0; nco_valid = 1'b1; nco_sin = 99; adc_data = 99;
    tick(); tick(); tick();
    nco_valid = 1'b0; clken = 1'b1;
    send(2, 5); send(2, 5);
    check("stall_early", out_valid, 0);
    tick();
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 40);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
